// File: rtl/core_pkg.sv
// Shared definitions for the 3-stage core front end: widths, FSM state
// encoding, default NOP word and a PC alignment helper.
package core_pkg;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned REG_AW  = 5;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned CNT_W   = 2;

   // addi x0, x0, 0
   localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0013;

   // Fetch FSM state encoding (plain vector constants for legacy tools)
   typedef logic [1:0] fsm_state_t;
   localparam fsm_state_t ST_FILL     = 2'd0;
   localparam fsm_state_t ST_RUN      = 2'd1;
   localparam fsm_state_t ST_STALL    = 2'd2;
   localparam fsm_state_t ST_REDIRECT = 2'd3;

   // Computed fetch targets are always word aligned
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register with load, hold and squash. An invalid slot
// presents NOP_INSTR to decode.
// Ports:
//   clk, rst      clock, async active-high reset
//   load_i        capture instr_i/pc_i and mark the slot valid
//   squash_i      invalidate the slot (wins over load_i)
//   instr_i/pc_i  fetched instruction and its address
//   instr_o/pc_o  held instruction (NOP when invalid) and its address
//   valid_o       slot holds a live instruction
module fetch_if_id_reg
   import core_pkg::*;
#(
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               squash_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [PC_W-1:0]    pc_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [PC_W-1:0]    pc_o,
   output logic               valid_o
);

   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               valid_q, valid_d;

   // Next-state: squash > load > hold
   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (squash_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         instr_d = instr_i;
         pc_d    = pc_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign instr_o = valid_q ? instr_q : NOP_INSTR;
   assign pc_o    = pc_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Front end of the 3-stage core: PC, IF/ID register, branch-target capture,
// load-use hazard detection and fetch redirection.
// Ports:
//   clk, rst                  clock, async active-high reset
//   imem_instr                instruction word at pc (combinational imem)
//   rs1, rs2, uses_rs2        ID-stage source operands
//   is_branch, jump, imm_val  ID-stage control and byte offset
//   beq, bneq, bge, blt       EX/MEM branch-taken flags
//   EX_MEM_regwrite/rd/lb     EX/MEM writeback info for load-use detection
//   pc                        fetch address
//   IF_ID_instr, input_pc     instruction held for decode and its PC
//   stall                     bubble into EX/MEM, hold PC and IF/ID
//   branch_flush              kill the ID/EX instruction this cycle
// Build option: FETCH_PERF_CNT_EN adds saturating perf_taken/perf_stall.
module fetch_hazard_ctrl
   import core_pkg::*;
#(
   parameter logic [PC_W-1:0]    RESET_PC     = 32'h0000_0000,
   parameter logic [INSTR_W-1:0] NOP_INSTR    = NOP_INSTR_DEF,
   parameter int unsigned        STALL_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic [REG_AW-1:0]  rs1,
   input  logic [REG_AW-1:0]  rs2,
   input  logic               uses_rs2,
   input  logic               is_branch,
   input  logic               jump,
   input  logic [PC_W-1:0]    imm_val,
   input  logic               beq,
   input  logic               bneq,
   input  logic               bge,
   input  logic               blt,
   input  logic               EX_MEM_regwrite,
   input  logic [REG_AW-1:0]  EX_MEM_rd,
   input  logic               EX_MEM_lb,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] IF_ID_instr,
   output logic [PC_W-1:0]    input_pc,
   output logic               stall,
   output logic               branch_flush
`ifdef FETCH_PERF_CNT_EN
  ,output logic [31:0]        perf_taken
  ,output logic [31:0]        perf_stall
`endif
);

   localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

   fsm_state_t         state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    tgt_q, tgt_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               taken;
   logic               hz;
   logic               stall_c;
   logic               ifid_load;
   logic               ifid_squash;
   logic               ifid_valid;
   logic [PC_W-1:0]    ifid_pc;

   assign taken = beq | bneq | bge | blt;

   // Load-use: the EX/MEM load's result is not yet available to ID
   assign hz = EX_MEM_lb & EX_MEM_regwrite & (EX_MEM_rd != '0) & ifid_valid &
               ((EX_MEM_rd == rs1) | (uses_rs2 & (EX_MEM_rd == rs2)));

   // Fetch FSM next-state and control
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      stall_c     = 1'b0;
      ifid_load   = 1'b0;
      ifid_squash = 1'b0;
      case (state_q)
         ST_FILL: begin
            ifid_load = 1'b1;
            pc_d      = pc_q + PC_STEP;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            if (taken) begin
               pc_d        = tgt_q;
               ifid_squash = 1'b1;
               state_d     = ST_REDIRECT;
            end else if (hz) begin
               stall_c = 1'b1;
               cnt_d   = CNT_W'(STALL_CYCLES - 1);
               if (STALL_CYCLES > 1) begin
                  state_d = ST_STALL;
               end
            end else if (jump && ifid_valid) begin
               pc_d        = align_pc(ifid_pc + imm_val);
               ifid_squash = 1'b1;
            end else begin
               ifid_load = 1'b1;
               pc_d      = pc_q + PC_STEP;
            end
         end
         ST_STALL: begin
            if (taken) begin
               pc_d        = tgt_q;
               ifid_squash = 1'b1;
               cnt_d       = '0;
               state_d     = ST_REDIRECT;
            end else begin
               stall_c = 1'b1;
               cnt_d   = cnt_q - CNT_W'(1);
               // the remaining count includes this cycle's bubble
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_REDIRECT: begin
            ifid_load = 1'b1;
            pc_d      = pc_q + PC_STEP;
            state_d   = ST_RUN;
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   // Branch target is computed while the branch sits in ID so it is ready
   // the cycle data_path reports the outcome from EX/MEM
   always_comb begin
      tgt_d = tgt_q;
      if (ifid_valid && is_branch && !stall_c && !taken) begin
         tgt_d = align_pc(ifid_pc + imm_val);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FILL;
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
      end
   end

   fetch_if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk      (clk),
      .rst      (rst),
      .load_i   (ifid_load),
      .squash_i (ifid_squash),
      .instr_i  (imem_instr),
      .pc_i     (pc_q),
      .instr_o  (IF_ID_instr),
      .pc_o     (ifid_pc),
      .valid_o  (ifid_valid)
   );

   assign pc           = pc_q;
   assign input_pc     = ifid_pc;
   assign stall        = stall_c & ~rst;
   assign branch_flush = taken & ~rst;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_taken_q, perf_taken_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   // Saturating event counters
   always_comb begin
      perf_taken_d = perf_taken_q;
      perf_stall_d = perf_stall_q;
      if (branch_flush && !(&perf_taken_q)) begin
         perf_taken_d = perf_taken_q + 32'd1;
      end
      if (stall && !(&perf_stall_q)) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_taken_q <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_taken_q <= perf_taken_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_taken = perf_taken_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed-vector bench for fetch_hazard_ctrl: default instance, a
// STALL_CYCLES=3 instance and a RESET_PC=FFFF_FFF8 instance for PC wrap.
module tb_fetch_hazard_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic [4:0]  rs1, rs2, ex_rd;
   logic        uses_rs2, is_branch, jump;
   logic [31:0] imm_val;
   logic        beq, bneq, bge, blt;
   logic        ex_regwrite, ex_lb;

   logic [31:0] d1_pc, d1_ifid, d1_ipc, d1_imem;
   logic        d1_stall, d1_flush;
   logic [31:0] d3_pc, d3_ifid, d3_ipc, d3_imem;
   logic        d3_stall, d3_flush;
   logic [31:0] dw_pc, dw_ifid, dw_ipc, dw_imem;
   logic        dw_stall, dw_flush;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] d1_ptaken, d1_pstall, d3_ptaken, d3_pstall, dw_ptaken, dw_pstall;
`endif

   int unsigned vec_cnt;
   int unsigned err_cnt;

   assign d1_imem = 32'h1111_0000 + d1_pc;
   assign d3_imem = 32'h1111_0000 + d3_pc;
   assign dw_imem = 32'h1111_0000 + dw_pc;

   fetch_hazard_ctrl u_d1 (
      .clk(clk), .rst(rst), .imem_instr(d1_imem),
      .rs1(rs1), .rs2(rs2), .uses_rs2(uses_rs2), .is_branch(is_branch),
      .jump(jump), .imm_val(imm_val),
      .beq(beq), .bneq(bneq), .bge(bge), .blt(blt),
      .EX_MEM_regwrite(ex_regwrite), .EX_MEM_rd(ex_rd), .EX_MEM_lb(ex_lb),
      .pc(d1_pc), .IF_ID_instr(d1_ifid), .input_pc(d1_ipc),
      .stall(d1_stall), .branch_flush(d1_flush)
`ifdef FETCH_PERF_CNT_EN
     ,.perf_taken(d1_ptaken), .perf_stall(d1_pstall)
`endif
   );

   fetch_hazard_ctrl #(.STALL_CYCLES(3)) u_d3 (
      .clk(clk), .rst(rst), .imem_instr(d3_imem),
      .rs1(rs1), .rs2(rs2), .uses_rs2(uses_rs2), .is_branch(is_branch),
      .jump(jump), .imm_val(imm_val),
      .beq(beq), .bneq(bneq), .bge(bge), .blt(blt),
      .EX_MEM_regwrite(ex_regwrite), .EX_MEM_rd(ex_rd), .EX_MEM_lb(ex_lb),
      .pc(d3_pc), .IF_ID_instr(d3_ifid), .input_pc(d3_ipc),
      .stall(d3_stall), .branch_flush(d3_flush)
`ifdef FETCH_PERF_CNT_EN
     ,.perf_taken(d3_ptaken), .perf_stall(d3_pstall)
`endif
   );

   fetch_hazard_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_dw (
      .clk(clk), .rst(rst), .imem_instr(dw_imem),
      .rs1(rs1), .rs2(rs2), .uses_rs2(uses_rs2), .is_branch(is_branch),
      .jump(jump), .imm_val(imm_val),
      .beq(beq), .bneq(bneq), .bge(bge), .blt(blt),
      .EX_MEM_regwrite(ex_regwrite), .EX_MEM_rd(ex_rd), .EX_MEM_lb(ex_lb),
      .pc(dw_pc), .IF_ID_instr(dw_ifid), .input_pc(dw_ipc),
      .stall(dw_stall), .branch_flush(dw_flush)
`ifdef FETCH_PERF_CNT_EN
     ,.perf_taken(dw_ptaken), .perf_stall(dw_pstall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_hz();
      ex_lb = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
      rs1 = 5'd0; rs2 = 5'd0; uses_rs2 = 1'b0;
   endtask

   // Pulse reset and release it mid-cycle; returns with the FSM in FILL
   task automatic do_reset();
      rst = 1'b1;
      #1;
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   initial begin
      vec_cnt = 0; err_cnt = 0;
      rst = 1'b1;
      clear_hz();
      is_branch = 1'b0; jump = 1'b0; imm_val = 32'd0;
      beq = 1'b0; bneq = 1'b0; bge = 1'b0; blt = 1'b0;

      // Reset state, with a taken flag present during reset
      #2 beq = 1'b1;
      #1;
      check_vec("rst_flush",  32'(d1_flush), 32'd0);
      check_vec("rst_stall",  32'(d1_stall), 32'd0);
      check_vec("rst_pc",     d1_pc, 32'd0);
      check_vec("rst_ifid",   d1_ifid, NOP);
      check_vec("rst_ipc",    d1_ipc, 32'd0);
      check_vec("rst_pc_w",   dw_pc, 32'hFFFF_FFF8);
      beq = 1'b0;

      // Release and sequential fetch
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_vec("fill_ifid", d1_ifid, NOP);
      check_vec("fill_pc",   d1_pc, 32'd0);
      step();
      check_vec("seq1_pc",   d1_pc, 32'h4);
      check_vec("seq1_ifid", d1_ifid, 32'h1111_0000);
      check_vec("seq1_ipc",  d1_ipc, 32'h0);
      check_vec("wrap1_pc",  dw_pc, 32'hFFFF_FFFC);
      check_vec("wrap1_ipc", dw_ipc, 32'hFFFF_FFF8);
      step();
      check_vec("seq2_pc",   d1_pc, 32'h8);
      check_vec("seq2_ifid", d1_ifid, 32'h1111_0004);
      check_vec("wrap2_pc",  dw_pc, 32'h0);
      step();
      check_vec("seq3_pc",   d1_pc, 32'hC);
      check_vec("seq3_ipc",  d1_ipc, 32'h8);

      // Load-use on rs1: 1 bubble (d1) versus 3 bubbles (d3)
      ex_lb = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; rs1 = 5'd5;
      #1;
      check_vec("lu_stall1",  32'(d1_stall), 32'd1);
      check_vec("lu_stall3",  32'(d3_stall), 32'd1);
      step();
      clear_hz();
      #1;
      check_vec("lu_hold_pc",   d1_pc, 32'hC);
      check_vec("lu_hold_ifid", d1_ifid, 32'h1111_0008);
      check_vec("lu_end1",      32'(d1_stall), 32'd0);
      check_vec("lu_s3_c2",     32'(d3_stall), 32'd1);
      step();
      check_vec("lu_resume_pc", d1_pc, 32'h10);
      check_vec("lu_s3_c3",     32'(d3_stall), 32'd1);
      check_vec("lu_s3_pc",     d3_pc, 32'hC);
      step();
      check_vec("lu_s3_end",    32'(d3_stall), 32'd0);
      check_vec("lu_s3_pc2",    d3_pc, 32'hC);
      step();
      check_vec("lu_s3_resume", d3_pc, 32'h10);

      // rd = x0 never hazards
      ex_lb = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd0; rs1 = 5'd0;
      #1;
      check_vec("x0_stall1", 32'(d1_stall), 32'd0);
      check_vec("x0_stall3", 32'(d3_stall), 32'd0);

      // Reset asserted while d3 sits in STALL
      ex_rd = 5'd5; rs1 = 5'd5;
      step();
      clear_hz();
      #1;
      check_vec("mid_stall3", 32'(d3_stall), 32'd1);
      rst = 1'b1;
      #1;
      check_vec("mid_rst_stall", 32'(d3_stall), 32'd0);
      check_vec("mid_rst_pc",    d3_pc, 32'd0);
      check_vec("mid_rst_ifid",  d3_ifid, NOP);
      check_vec("mid_rst_ipc",   d3_ipc, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Taken branch: target captured in ID, redirect the next cycle
      for (int i = 0; i < 5; i++) step();
      check_vec("br_ipc", d1_ipc, 32'h10);
      is_branch = 1'b1; imm_val = 32'h20;
      step();
      is_branch = 1'b0; imm_val = 32'd0; beq = 1'b1;
      #1;
      check_vec("br_flush", 32'(d1_flush), 32'd1);
      check_vec("br_stall", 32'(d1_stall), 32'd0);
      check_vec("br_pc0",   d1_pc, 32'h18);
      step();
      beq = 1'b0;
      #1;
      check_vec("br_pc",    d1_pc, 32'h30);
      check_vec("br_ifid",  d1_ifid, NOP);
      check_vec("br_noflush", 32'(d1_flush), 32'd0);
      step();
      check_vec("br_pc2",   d1_pc, 32'h34);
      check_vec("br_ifid2", d1_ifid, 32'h1111_0030);
      check_vec("br_ipc2",  d1_ipc, 32'h30);

      // Jump backwards by 8 from input_pc=8
      do_reset();
      for (int i = 0; i < 3; i++) step();
      jump = 1'b1; imm_val = 32'hFFFF_FFF8;
      #1;
      check_vec("jmp_flush", 32'(d1_flush), 32'd0);
      check_vec("jmp_stall", 32'(d1_stall), 32'd0);
      step();
      jump = 1'b0; imm_val = 32'd0;
      #1;
      check_vec("jmp_pc",    d1_pc, 32'h0);
      check_vec("jmp_ifid",  d1_ifid, NOP);
      step();
      check_vec("jmp_pc2",   d1_pc, 32'h4);
      check_vec("jmp_ifid2", d1_ifid, 32'h1111_0000);
      check_vec("jmp_ipc2",  d1_ipc, 32'h0);

      // Simultaneous load-use (rs2) and taken blt: flush wins
      is_branch = 1'b1; imm_val = 32'h40;
      step();
      is_branch = 1'b0; imm_val = 32'd0; blt = 1'b1;
      ex_lb = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7; rs2 = 5'd7; uses_rs2 = 1'b1;
      #1;
      check_vec("both_stall", 32'(d1_stall), 32'd0);
      check_vec("both_flush", 32'(d1_flush), 32'd1);
      step();
      blt = 1'b0;
      clear_hz();
      #1;
      check_vec("both_pc",   d1_pc, 32'h40);
      check_vec("both_ifid", d1_ifid, NOP);

`ifdef FETCH_PERF_CNT_EN
      // Two taken cycles and three stall cycles on d1
      do_reset();
      check_vec("perf_t0", d1_ptaken, 32'd0);
      step(); step();
      beq = 1'b1; step(); beq = 1'b0;
      step();
      bge = 1'b1; step(); bge = 1'b0;
      step();
      ex_lb = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd3; rs1 = 5'd3;
      step(); step(); step();
      clear_hz();
      #1;
      check_vec("perf_taken", d1_ptaken, 32'd2);
      check_vec("perf_stall", d1_pstall, 32'd3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
